ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2_500_000, is the maximum clk cycles allowed between a prefix byte (E0/F0) and the byte that completes it (100 ms at 25 MHz).
REQ-002 clk  input  1  pixel-domain clock; the same clock that drives the upstream ps2_keyboard.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 keycode  input  8  byte from ps2_keyboard; valid while key_valid is high.
REQ-005 key_valid  input  1  byte-available level/strobe from ps2_keyboard.
REQ-006 arrows  output  4  held state {down, right, left, up}; 1 = key currently pressed; bit order matches the char_driver controls bus.
REQ-007 arrow_press  output  4  one-cycle pulse per bit on 0->1 of the matching arrows bit.
REQ-008 code  output  8  last completed make/break code, prefixes stripped.
REQ-009 code_ext  output  1  1 if code was E0-prefixed.
REQ-010 make_pulse  output  1  one-cycle pulse when a make code completes (typematic repeats included).
REQ-011 break_pulse  output  1  one-cycle pulse when a break code completes.
REQ-012 err_pulse  output  1  one-cycle pulse on protocol error or timeout.

Function
REQ-013 Byte acceptance: register kv_d <= key_valid; a byte is accepted on each clk edge where key_valid=1 and kv_d=0; a level held high counts once.
REQ-014 Latency: pulses, code, code_ext and arrows update on the same edge that accepts the byte; pulses are visible for exactly the following cycle.
REQ-015 FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-016 IDLE: E0 -> EXT; F0 -> BRK; E1, AA, FA, FE, EE discarded, stay IDLE; 00 or FF -> err_pulse, arrows cleared, stay IDLE; any other byte -> make completes, code_ext=0, stay IDLE.
REQ-017 EXT: F0 -> EXT_BRK; E0 -> stay EXT (duplicate prefix tolerated); 12 or 59 (fake-shift) discarded -> IDLE; other -> make completes, code_ext=1 -> IDLE.
REQ-018 BRK: E0 or F0 -> err_pulse -> IDLE; other -> break completes, code_ext=0 -> IDLE.
REQ-019 EXT_BRK: E0 or F0 -> err_pulse -> IDLE; 12 or 59 discarded -> IDLE; other -> break completes, code_ext=1 -> IDLE.
REQ-020 Arrow mapping, independent of code_ext: 75 -> up(bit0), 6B -> left(bit1), 74 -> right(bit2), 72 -> down(bit3); make sets the bit, break clears it.
REQ-021 arrow_press fires only when the bit was 0; typematic repeat makes with the bit already 1 give make_pulse only.
REQ-022 Timeout counter: cleared on every accepted byte and held at 0 in IDLE; increments in EXT/BRK/EXT_BRK; reaching TIMEOUT_CYCLES-1 forces IDLE and err_pulse; arrows unchanged.
REQ-023 An accepted byte on the same edge as timeout expiry takes priority: the byte is processed and there is no timeout error.
REQ-024 Multiple arrows may be held simultaneously; each bit is independent.
REQ-025 Pulses are mutually exclusive per accepted byte, except err_pulse with arrows clear on 00/FF.

Reset
REQ-026 While rst=1: state=IDLE, counter=0, kv_d=1, and arrows, arrow_press, code, code_ext, make_pulse, break_pulse, err_pulse all =0.
REQ-027 kv_d resets to 1 so a key_valid held high across reset release is not accepted; the first acceptance requires a 0->1 transition.
REQ-028 Reset asserted mid-sequence (e.g. after E0) discards the partial sequence; the next byte is decoded from IDLE.

Verification
REQ-029 Bytes E0,75 then E0,F0,75 -> arrows 0001 then 0000; arrow_press[0] once; make_pulse then break_pulse; code=75 and code_ext=1 both times.
REQ-030 Bytes 1C,1C,1C,F0,1C -> three make_pulse, one break_pulse, code=1C, code_ext=0, arrows stays 0000, no arrow_press.
REQ-031 Bytes 75,6B, then F0,75 -> arrows 0001, 0011, 0010; arrow_press pulses bit0 then bit1.
REQ-032 Byte E0 then idle TIMEOUT_CYCLES (set to 16 in the bench) -> err_pulse after 16 cycles, state IDLE; next byte 74 -> arrows 0100, code_ext=0.
REQ-033 Bytes F0,F0 -> err_pulse, no break_pulse; byte FF with arrows=1111 -> err_pulse, arrows 0000.
REQ-034 key_valid held high 5 cycles with 72 -> one make_pulse; reset asserted after E0, released, then 72 -> code_ext=0, arrows 1000.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 make/break sequences from ps2_keyboard into held arrow-key state,
// the last completed code, and single-cycle make/break/error pulses.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keycode,
    input  logic       key_valid,
    output logic [3:0] arrows,
    output logic [3:0] arrow_press,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic       err_pulse
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kv_q;
    logic [3:0]    arrows_q, arrows_d, press_q, press_d;
    logic [7:0]    code_q, code_d;
    logic          ext_q, ext_d, mk_q, mk_d, br_q, br_d, err_q, err_d;
    logic          accept, do_make, do_break, is_ext;
    logic [3:0]    mask;

    assign accept = key_valid & ~kv_q;

    always_comb begin
        unique case (keycode)
            8'h75:   mask = 4'b0001;
            8'h6B:   mask = 4'b0010;
            8'h74:   mask = 4'b0100;
            8'h72:   mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        arrows_d = arrows_q;
        press_d  = 4'b0000;
        code_d   = code_q;
        ext_d    = ext_q;
        mk_d     = 1'b0;
        br_d     = 1'b0;
        err_d    = 1'b0;
        do_make  = 1'b0;
        do_break = 1'b0;
        is_ext   = 1'b0;

        if (accept) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    unique case (keycode)
                        8'hE0: state_d = EXT;
                        8'hF0: state_d = BRK;
                        8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
                        8'h00, 8'hFF: begin
                            err_d    = 1'b1;
                            arrows_d = 4'b0000;
                        end
                        default: do_make = 1'b1;
                    endcase
                end
                EXT: begin
                    unique case (keycode)
                        8'hF0: state_d = EXT_BRK;
                        8'hE0: state_d = EXT;
                        // fake-shift bytes wrap extended keys in some modes; ignore them
                        8'h12, 8'h59: state_d = IDLE;
                        default: begin
                            do_make = 1'b1;
                            is_ext  = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
                BRK: begin
                    state_d = IDLE;
                    if (keycode == 8'hE0 || keycode == 8'hF0) err_d = 1'b1;
                    else do_break = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    unique case (keycode)
                        8'hE0, 8'hF0: err_d = 1'b1;
                        8'h12, 8'h59: ;
                        default: begin
                            do_break = 1'b1;
                            is_ext   = 1'b1;
                        end
                    endcase
                end
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        if (do_make || do_break) begin
            code_d = keycode;
            ext_d  = is_ext;
            mk_d   = do_make;
            br_d   = do_break;
            if (do_make) begin
                press_d  = mask & ~arrows_q;
                arrows_d = arrows_q | mask;
            end else begin
                arrows_d = arrows_q & ~mask;
            end
        end
    end

    // kv_q resets high so a level held through reset release is not taken as a new byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            kv_q     <= 1'b1;
            arrows_q <= 4'b0000;
            press_q  <= 4'b0000;
            code_q   <= 8'h00;
            ext_q    <= 1'b0;
            mk_q     <= 1'b0;
            br_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kv_q     <= key_valid;
            arrows_q <= arrows_d;
            press_q  <= press_d;
            code_q   <= code_d;
            ext_q    <= ext_d;
            mk_q     <= mk_d;
            br_q     <= br_d;
            err_q    <= err_d;
        end
    end

    assign arrows      = arrows_q;
    assign arrow_press = press_q;
    assign code        = code_q;
    assign code_ext    = ext_q;
    assign make_pulse  = mk_q;
    assign break_pulse = br_q;
    assign err_pulse   = err_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: scenario tasks with hand-computed expectations.
module tb_ps2_key_tracker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] keycode = 8'h72;
    logic       key_valid = 1'b1;
    logic [3:0] arrows, arrow_press;
    logic [7:0] code;
    logic       code_ext, make_pulse, break_pulse, err_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_key_tracker #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .keycode(keycode), .key_valid(key_valid),
        .arrows(arrows), .arrow_press(arrow_press), .code(code), .code_ext(code_ext),
        .make_pulse(make_pulse), .break_pulse(break_pulse), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    // Entered and left at a negedge; on return the accepting edge has just passed.
    task automatic send(input logic [7:0] b);
        key_valid = 1'b0;
        @(negedge clk);
        keycode   = b;
        key_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if ({arrows, arrow_press, code, code_ext, make_pulse, break_pulse, err_pulse} !== 20'h0) begin
            n_bad++; $display("FAIL reset_outputs got=%h want=0", {arrows, arrow_press, code, code_ext, make_pulse, break_pulse, err_pulse});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({make_pulse, arrows} !== 5'b0) begin
            n_bad++; $display("FAIL reset_held_valid got mk=%b arrows=%b want 0/0000", make_pulse, arrows);
        end
    endtask

    task automatic test_ext_arrow;
        send(8'hE0);
        n_cmp++; if (make_pulse !== 1'b0) begin n_bad++; $display("FAIL ext_prefix_mk got=%b want=0", make_pulse); end
        send(8'h75);
        n_cmp++; if ({arrows, arrow_press, make_pulse, code, code_ext} !== {4'b0001, 4'b0001, 1'b1, 8'h75, 1'b1}) begin
            n_bad++; $display("FAIL ext_make got ar=%b pr=%b mk=%b code=%h ext=%b", arrows, arrow_press, make_pulse, code, code_ext);
        end
        send(8'hE0); send(8'hF0);
        n_cmp++; if ({make_pulse, break_pulse, err_pulse} !== 3'b0) begin
            n_bad++; $display("FAIL ext_brk_prefix got pulses=%b want=000", {make_pulse, break_pulse, err_pulse});
        end
        send(8'h75);
        n_cmp++; if ({arrows, arrow_press, break_pulse, make_pulse, code, code_ext} !== {4'b0000, 4'b0000, 2'b10, 8'h75, 1'b1}) begin
            n_bad++; $display("FAIL ext_break got ar=%b pr=%b br=%b mk=%b code=%h ext=%b", arrows, arrow_press, break_pulse, make_pulse, code, code_ext);
        end
    endtask

    task automatic test_typematic;
        for (int i = 0; i < 3; i++) begin
            send(8'h1C);
            n_cmp++; if ({make_pulse, arrow_press, arrows, code, code_ext} !== {1'b1, 8'h00, 8'h1C, 1'b0}) begin
                n_bad++; $display("FAIL typematic_%0d got mk=%b pr=%b ar=%b code=%h ext=%b", i, make_pulse, arrow_press, arrows, code, code_ext);
            end
        end
        send(8'hF0); send(8'h1C);
        n_cmp++; if ({break_pulse, make_pulse, code, code_ext} !== {2'b10, 8'h1C, 1'b0}) begin
            n_bad++; $display("FAIL typematic_break got br=%b mk=%b code=%h ext=%b", break_pulse, make_pulse, code, code_ext);
        end
    endtask

    task automatic test_multi_arrow;
        send(8'h75);
        n_cmp++; if ({arrows, arrow_press} !== 8'b0001_0001) begin n_bad++; $display("FAIL multi_up got ar=%b pr=%b", arrows, arrow_press); end
        send(8'h6B);
        n_cmp++; if ({arrows, arrow_press} !== 8'b0011_0010) begin n_bad++; $display("FAIL multi_left got ar=%b pr=%b", arrows, arrow_press); end
        send(8'hF0); send(8'h75);
        n_cmp++; if ({arrows, arrow_press} !== 8'b0010_0000) begin n_bad++; $display("FAIL multi_rel_up got ar=%b pr=%b", arrows, arrow_press); end
        send(8'h75);
        send(8'h75);
        n_cmp++; if ({arrows, arrow_press, make_pulse} !== 9'b0011_0000_1) begin n_bad++; $display("FAIL multi_repeat got ar=%b pr=%b mk=%b", arrows, arrow_press, make_pulse); end
        send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h6B);
        n_cmp++; if (arrows !== 4'b0000) begin n_bad++; $display("FAIL multi_clear got ar=%b want=0000", arrows); end
    endtask

    task automatic test_timeout;
        int first = -1;
        send(8'hE0);
        key_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (err_pulse === 1'b1 && first < 0) first = n;
        end
        n_cmp++; if (first !== 16) begin n_bad++; $display("FAIL timeout_cycles got=%0d want=16", first); end
        send(8'h74);
        n_cmp++; if ({arrows, code_ext, make_pulse, code} !== {4'b0100, 1'b0, 1'b1, 8'h74}) begin
            n_bad++; $display("FAIL timeout_next got ar=%b ext=%b mk=%b code=%h", arrows, code_ext, make_pulse, code);
        end
    endtask

    task automatic test_errors;
        send(8'hF0); send(8'hF0);
        n_cmp++; if ({err_pulse, break_pulse, make_pulse} !== 3'b100) begin
            n_bad++; $display("FAIL f0f0 got err=%b br=%b mk=%b want 1/0/0", err_pulse, break_pulse, make_pulse);
        end
        send(8'h75); send(8'h6B); send(8'h74); send(8'h72);
        n_cmp++; if (arrows !== 4'b1111) begin n_bad++; $display("FAIL all_arrows got=%b want=1111", arrows); end
        send(8'hFF);
        n_cmp++; if ({err_pulse, arrows, make_pulse} !== 6'b1_0000_0) begin
            n_bad++; $display("FAIL ff_clear got err=%b ar=%b mk=%b", err_pulse, arrows, make_pulse);
        end
    endtask

    task automatic test_level_and_midreset;
        int mk = 0;
        key_valid = 1'b0;
        @(negedge clk);
        keycode = 8'h72; key_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (make_pulse === 1'b1) mk++;
        end
        n_cmp++; if (mk !== 1) begin n_bad++; $display("FAIL held_level got makes=%0d want=1", mk); end
        n_cmp++; if (arrows !== 4'b1000) begin n_bad++; $display("FAIL held_arrow got=%b want=1000", arrows); end
        send(8'hF0); send(8'h72);
        send(8'hE0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(8'h72);
        n_cmp++; if ({code_ext, arrows, make_pulse, code} !== {1'b0, 4'b1000, 1'b1, 8'h72}) begin
            n_bad++; $display("FAIL midreset got ext=%b ar=%b mk=%b code=%h", code_ext, arrows, make_pulse, code);
        end
    endtask

    initial begin
        test_reset;
        test_ext_arrow;
        test_typematic;
        test_multi_arrow;
        test_timeout;
        test_errors;
        test_level_and_midreset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
